// File: rtl/ddr_port_reader_pkg.sv
// ddr_port_reader_pkg: shared definitions for the MIG port readers and writers.
// Holds the reader state encoding, MIG command opcodes and burst geometry.
package ddr_port_reader_pkg;

  typedef enum logic [2:0] {
    WAIT_CALIB = 3'd0,
    IDLE       = 3'd1,
    CMD        = 3'd2,
    WAIT_DATA  = 3'd3,
    STREAM     = 3'd4,
    DONE       = 3'd5
  } reader_state_e;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  localparam int BURST_WORDS = 64;
  localparam int BURST_BYTES = 256;

  // MIG encodes burst length as (words - 1)
  localparam logic [5:0] MIG_BURST_LEN = 6'(BURST_WORDS - 1);

endpackage

// File: rtl/ddr_rd_skid.sv
// ddr_rd_skid: pixel output register with valid/ready handshake.
// A word is loaded only when the register is empty or being drained, so the
// held word never changes while the consumer stalls.
module ddr_rd_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic        valid_o
);

  logic [31:0] data_q;
  logic        valid_q;

  // Capture a new word on load; drop valid once the consumer has taken it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ddr_port_reader.sv
// ddr_port_reader: reads whole frames from MIG port 1 in 64-word bursts and
// streams them out as 32-bit pixels. Define DDR_READER_FRAME_SWAP_EN to pick
// between two frame buffers with frame_sel; otherwise frame_sel is ignored.
module ddr_port_reader
  import ddr_port_reader_pkg::*;
#(
  parameter int          FRAME_WORDS = 1310720,
  parameter logic [29:0] BASE_ADDR   = 30'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_calib_done,
  input  logic        frame_start,
  input  logic        frame_sel,
  input  logic        p1_cmd_full,
  output logic        p1_cmd_en,
  output logic [2:0]  p1_cmd_instr,
  output logic [5:0]  p1_cmd_bl,
  output logic [29:0] p1_cmd_byte_addr,
  input  logic        p1_rd_empty,
  input  logic [6:0]  p1_rd_count,
  input  logic [31:0] p1_rd_data,
  input  logic        p1_rd_overflow,
  output logic        p1_rd_en,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done,
  output logic        overflow_err
);

  localparam logic [29:0] FRAME_BYTES = 30'(FRAME_WORDS * 4);
  localparam logic [6:0]  LAST_WORD   = 7'(BURST_WORDS - 1);

  reader_state_e state_q;
  logic          calibMeta_q, calibOk_q;
  logic [29:0]   ptr_q, frameEnd_q;
  logic [6:0]    wordCnt_q;
  logic          pending_q, pendingSel_q;
  logic          cmdEn_q;
  logic [2:0]    cmdInstr_q;
  logic [5:0]    cmdBl_q;
  logic [29:0]   cmdAddr_q;
  logic          frameDone_q, overflowErr_q;
  logic          rdEn, pixValid, startSel;
  logic [29:0]   startBase;

  // A queued request carries the buffer select it was issued with
  assign startSel = pending_q ? pendingSel_q : frame_sel;

`ifdef DDR_READER_FRAME_SWAP_EN
  logic unusedInputs;
  assign startBase    = BASE_ADDR + (startSel ? FRAME_BYTES : 30'd0);
  assign unusedInputs = ^p1_rd_count;
`else
  logic unusedInputs;
  assign startBase    = BASE_ADDR;
  assign unusedInputs = ^{p1_rd_count, startSel};
`endif

  // Pop the FWFT FIFO whenever the pixel register can accept a word
  assign rdEn = (state_q == STREAM) && calibOk_q && !p1_rd_empty && (!pixValid || pix_ready);

  // Bring the asynchronous calibration flag into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calibMeta_q <= 1'b0;
      calibOk_q   <= 1'b0;
    end else begin
      calibMeta_q <= mem_calib_done;
      calibOk_q   <= calibMeta_q;
    end
  end

  // Any read-FIFO overflow is latched until the next reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflowErr_q <= 1'b0;
    else if (p1_rd_overflow) overflowErr_q <= 1'b1;
  end

  // Frame sequencer: issue bursts, count streamed words, signal frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_CALIB;
      ptr_q        <= BASE_ADDR;
      frameEnd_q   <= '0;
      wordCnt_q    <= '0;
      pending_q    <= 1'b0;
      pendingSel_q <= 1'b0;
      cmdEn_q      <= 1'b0;
      cmdInstr_q   <= '0;
      cmdBl_q      <= '0;
      cmdAddr_q    <= '0;
      frameDone_q  <= 1'b0;
    end else begin
      cmdEn_q     <= 1'b0;
      frameDone_q <= 1'b0;
      if (!calibOk_q) begin
        state_q      <= WAIT_CALIB;
        pending_q    <= 1'b0;
        pendingSel_q <= 1'b0;
      end else begin
        if (frame_start && state_q != IDLE) begin
          pending_q    <= 1'b1;
          pendingSel_q <= frame_sel;
        end
        unique case (state_q)
          WAIT_CALIB: state_q <= IDLE;
          IDLE: begin
            if (pending_q || frame_start) begin
              ptr_q      <= startBase;
              frameEnd_q <= startBase + FRAME_BYTES;
              wordCnt_q  <= '0;
              state_q    <= CMD;
              if (pending_q) begin
                pending_q    <= frame_start;
                pendingSel_q <= frame_sel;
              end
            end
          end
          CMD: begin
            if (!p1_cmd_full) begin
              cmdEn_q    <= 1'b1;
              cmdInstr_q <= MIG_CMD_READ;
              cmdBl_q    <= MIG_BURST_LEN;
              cmdAddr_q  <= ptr_q;
              ptr_q      <= ptr_q + 30'(BURST_BYTES);
              wordCnt_q  <= '0;
              state_q    <= WAIT_DATA;
            end
          end
          WAIT_DATA: if (!p1_rd_empty) state_q <= STREAM;
          STREAM: begin
            if (rdEn) begin
              wordCnt_q <= wordCnt_q + 7'd1;
              if (wordCnt_q == LAST_WORD) begin
                if (ptr_q < frameEnd_q) begin
                  state_q <= CMD;
                end else begin
                  state_q     <= DONE;
                  frameDone_q <= 1'b1;
                end
              end
            end
          end
          DONE: if (!pixValid) state_q <= IDLE;
          default: state_q <= WAIT_CALIB;
        endcase
      end
    end
  end

  ddr_rd_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (!calibOk_q),
    .load_i  (rdEn),
    .data_i  (p1_rd_data),
    .ready_i (pix_ready),
    .data_o  (pix_data),
    .valid_o (pixValid)
  );

  assign p1_cmd_en        = cmdEn_q;
  assign p1_cmd_instr     = cmdInstr_q;
  assign p1_cmd_bl        = cmdBl_q;
  assign p1_cmd_byte_addr = cmdAddr_q;
  assign p1_rd_en         = rdEn;
  assign pix_valid        = pixValid;
  assign frame_done       = frameDone_q;
  assign overflow_err     = overflowErr_q;

endmodule

// File: tb/tb_ddr_port_reader.sv
// tb_ddr_port_reader: drives ddr_port_reader against a behavioural MIG port
// model (command queue feeding a FWFT read FIFO) and checks the pixel stream
// against the words that each frame should contain.
module tb_ddr_port_reader;
  import ddr_port_reader_pkg::*;

  localparam int          FW   = 128;
  localparam logic [29:0] BASE = 30'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_calib_done = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_sel = 1'b0;
  logic        p1_cmd_full = 1'b0;
  logic        p1_cmd_en;
  logic [2:0]  p1_cmd_instr;
  logic [5:0]  p1_cmd_bl;
  logic [29:0] p1_cmd_byte_addr;
  logic        p1_rd_empty = 1'b1;
  logic [6:0]  p1_rd_count = '0;
  logic [31:0] p1_rd_data = '0;
  logic        p1_rd_overflow = 1'b0;
  logic        p1_rd_en;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        frame_done;
  logic        overflow_err;

  int total = 0;
  int bad = 0;

  logic [31:0] memQ[$];
  logic [31:0] expQ[$];
  logic [29:0] expAddrQ[$];
  int          doneCount = 0;
  int          cmdCount = 0;
  int          readyMode = 0;
  bit          gapMode = 1'b0;
  bit          dropReq = 1'b0;
  logic [31:0] seed = '0;

  ddr_port_reader #(.FRAME_WORDS(FW), .BASE_ADDR(BASE)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_calib_done   (mem_calib_done),
    .frame_start      (frame_start),
    .frame_sel        (frame_sel),
    .p1_cmd_full      (p1_cmd_full),
    .p1_cmd_en        (p1_cmd_en),
    .p1_cmd_instr     (p1_cmd_instr),
    .p1_cmd_bl        (p1_cmd_bl),
    .p1_cmd_byte_addr (p1_cmd_byte_addr),
    .p1_rd_empty      (p1_rd_empty),
    .p1_rd_count      (p1_rd_count),
    .p1_rd_data       (p1_rd_data),
    .p1_rd_overflow   (p1_rd_overflow),
    .p1_rd_en         (p1_rd_en),
    .pix_data         (pix_data),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .frame_done       (frame_done),
    .overflow_err     (overflow_err)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Contents of DDR at a given word index
  function automatic logic [31:0] memWord(input logic [29:0] wordIdx);
    return {2'b00, wordIdx} ^ seed;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A frame at byte address base is every consecutive word, one command per 256 bytes
  task automatic expectFrame(input logic [29:0] base);
    for (int k = 0; k < FW / BURST_WORDS; k++) expAddrQ.push_back(base + 30'(k * BURST_BYTES));
    for (int n = 0; n < FW; n++) expQ.push_back(memWord((base >> 2) + 30'(n)));
  endtask

  task automatic applyStimulus(input logic sel);
    @(posedge clk); #1;
    frame_start = 1'b1;
    frame_sel   = sel;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int target, input string tag);
    int n = 0;
    while (doneCount < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(doneCount >= target), 32'd1);
  endtask

  task automatic waitState(input reader_state_e st, input string tag);
    int n = 0;
    while (dut.state_q != st && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(dut.state_q), 32'(st));
  endtask

  // MIG port model and output scoreboard: sample at negedge, update at posedge+1
  initial begin : mig_model
    bit          doPop;
    bit          stallPrev;
    logic [31:0] stallData;
    int          holdoff;
    bit          gap;
    stallPrev = 1'b0;
    stallData = '0;
    holdoff   = 0;
    forever begin
      @(negedge clk);
      doPop = p1_rd_en;
      if (p1_rd_en) checkOutput("rd_en_on_empty", 32'(p1_rd_empty), 32'd0);
      if (p1_cmd_en) begin
        cmdCount++;
        checkOutput("cmd_expected", 32'(expAddrQ.size() > 0), 32'd1);
        if (expAddrQ.size() > 0) checkOutput("cmd_addr", {2'b00, p1_cmd_byte_addr}, {2'b00, expAddrQ.pop_front()});
        checkOutput("cmd_instr", 32'(p1_cmd_instr), 32'(3'b001));
        checkOutput("cmd_bl", 32'(p1_cmd_bl), 32'd63);
        for (int i = 0; i < BURST_WORDS; i++) memQ.push_back(memWord((p1_cmd_byte_addr >> 2) + 30'(i)));
        holdoff = int'($urandom_range(1, 4));
      end
      if (pix_valid && pix_ready) begin
        checkOutput("pix_expected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) checkOutput("pix_data", pix_data, expQ.pop_front());
      end
      if (stallPrev) begin
        checkOutput("stall_valid", 32'(pix_valid), 32'd1);
        checkOutput("stall_data", pix_data, stallData);
      end
      stallPrev = pix_valid && !pix_ready;
      stallData = pix_data;
      if (frame_done) doneCount++;

      @(posedge clk); #1;
      if (dropReq) begin
        memQ.delete();
        expQ.delete();
        expAddrQ.delete();
        stallPrev = 1'b0;
        holdoff   = 0;
        doPop     = 1'b0;
        dropReq   = 1'b0;
      end
      if (doPop && memQ.size() > 0) void'(memQ.pop_front());
      if (holdoff > 0) holdoff--;
      gap = gapMode && ($urandom_range(0, 3) == 0);
      p1_rd_empty = (memQ.size() == 0) || (holdoff > 0) || gap;
      p1_rd_data  = (memQ.size() > 0) ? memQ[0] : $urandom;
      p1_rd_count = (memQ.size() > 127) ? 7'd127 : 7'(memQ.size());
      case (readyMode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ~pix_ready;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Hard stop in case the design never reaches its milestones
  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Directed sequence of scenarios
  initial begin : stimulus
    logic [29:0] selBase;
    int          startDone;
    int          n;

    // Reset values while rst_n is low
    #2;
    checkOutput("rst_state", 32'(dut.state_q), 32'(WAIT_CALIB));
    checkOutput("rst_cmd_en", 32'(p1_cmd_en), 32'd0);
    checkOutput("rst_cmd_instr", 32'(p1_cmd_instr), 32'd0);
    checkOutput("rst_cmd_bl", 32'(p1_cmd_bl), 32'd0);
    checkOutput("rst_cmd_addr", 32'(p1_cmd_byte_addr), 32'd0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_pix_data", pix_data, 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_overflow", 32'(overflow_err), 32'd0);
    checkOutput("rst_rd_en", 32'(p1_rd_en), 32'd0);

    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(3);
    checkOutput("no_calib_stays", 32'(dut.state_q), 32'(WAIT_CALIB));
    mem_calib_done = 1'b1;
    waitState(IDLE, "calib_to_idle");

    // Basic frame, consumer always ready, data is the word index
    $display("[TB] basic frame");
    expectFrame(BASE);
    applyStimulus(1'b0);
    waitDone(1, "basic_done");
    waitCycles(20);
    checkOutput("basic_done_count", 32'(doneCount), 32'd1);
    checkOutput("basic_cmd_count", 32'(cmdCount), 32'd2);
    checkOutput("basic_words_left", 32'(expQ.size()), 32'd0);
    checkOutput("basic_idle", 32'(dut.state_q), 32'(IDLE));

    // Consumer toggles ready every cycle and the FIFO runs dry at random
    $display("[TB] toggling ready");
    readyMode = 1;
    gapMode   = 1'b1;
    expectFrame(BASE);
    applyStimulus(1'b0);
    waitDone(2, "toggle_done");
    waitCycles(20);
    checkOutput("toggle_words_left", 32'(expQ.size()), 32'd0);
    checkOutput("toggle_done_count", 32'(doneCount), 32'd2);

    // Command port back-pressure
    $display("[TB] command full");
    seed      = $urandom;
    readyMode = 2;
    p1_cmd_full = 1'b1;
    expectFrame(BASE);
    applyStimulus(1'b0);
    repeat (10) begin
      @(negedge clk);
      checkOutput("cmd_en_held", 32'(p1_cmd_en), 32'd0);
    end
    @(posedge clk); #1;
    p1_cmd_full = 1'b0;
    n = 0;
    while (!p1_cmd_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_pulse_seen", 32'(p1_cmd_en), 32'd1);
    @(negedge clk);
    checkOutput("cmd_pulse_width", 32'(p1_cmd_en), 32'd0);
    waitDone(3, "full_done");
    waitCycles(20);
    checkOutput("full_words_left", 32'(expQ.size()), 32'd0);

    // Second frame buffer select
    $display("[TB] frame select");
`ifdef DDR_READER_FRAME_SWAP_EN
    selBase = BASE + 30'(FW * 4);
`else
    selBase = BASE;
`endif
    expectFrame(selBase);
    applyStimulus(1'b1);
    n = 0;
    while (!p1_cmd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sel_first_addr", {2'b00, p1_cmd_byte_addr}, {2'b00, selBase});
    waitDone(4, "sel_done");
    waitCycles(20);
    checkOutput("sel_words_left", 32'(expQ.size()), 32'd0);

    // Requests during a frame: only one is remembered
    $display("[TB] pending request");
    readyMode = 0;
    gapMode   = 1'b0;
    startDone = doneCount;
    expectFrame(BASE);
    expectFrame(BASE);
    applyStimulus(1'b0);
    waitCycles(30);
    applyStimulus(1'b0);
    waitCycles(5);
    applyStimulus(1'b0);
    waitDone(startDone + 2, "pending_done");
    waitCycles(200);
    checkOutput("pending_done_count", 32'(doneCount), 32'(startDone + 2));
    checkOutput("pending_words_left", 32'(expQ.size()), 32'd0);
    checkOutput("pending_idle", 32'(dut.state_q), 32'(IDLE));

    // Calibration lost in the middle of a burst
    $display("[TB] calibration drop");
    expectFrame(BASE);
    applyStimulus(1'b0);
    waitState(STREAM, "drop_reach_stream");
    waitCycles(10);
    mem_calib_done = 1'b0;
    waitCycles(3);
    checkOutput("drop_state", 32'(dut.state_q), 32'(WAIT_CALIB));
    checkOutput("drop_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("drop_rd_en", 32'(p1_rd_en), 32'd0);
    checkOutput("drop_cmd_en", 32'(p1_cmd_en), 32'd0);
    dropReq = 1'b1;
    waitCycles(4);
    mem_calib_done = 1'b1;
    waitState(IDLE, "drop_recover_idle");
    waitCycles(10);
    checkOutput("drop_no_pending", 32'(dut.state_q), 32'(IDLE));
    startDone = doneCount;
    expectFrame(BASE);
    applyStimulus(1'b0);
    waitDone(startDone + 1, "recover_done");
    waitCycles(20);
    checkOutput("recover_words_left", 32'(expQ.size()), 32'd0);

    // Sticky overflow flag
    $display("[TB] overflow");
    checkOutput("ovf_before", 32'(overflow_err), 32'd0);
    @(posedge clk); #1;
    p1_rd_overflow = 1'b1;
    @(posedge clk); #1;
    p1_rd_overflow = 1'b0;
    waitCycles(2);
    checkOutput("ovf_set", 32'(overflow_err), 32'd1);
    waitCycles(30);
    checkOutput("ovf_sticky", 32'(overflow_err), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("ovf_reset", 32'(overflow_err), 32'd0);
    checkOutput("reset_again_state", 32'(dut.state_q), 32'(WAIT_CALIB));
    waitCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_port_reader.md
DDR_PORT_READER -- requirements
Module: ddr_port_reader

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 1310720, giving 32-bit words per frame (1280x1024).
REQ-002 SHALL have parameter BASE_ADDR, default 0, giving the frame 0 byte address.
REQ-003 SHALL have port clk  input  1  with all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  as the asynchronous, active-low reset.
REQ-005 SHALL have mem_calib_done  input  1  as the MIG calibration status.
REQ-006 SHALL have frame_start  input  1  as a one-cycle request to read one frame.
REQ-007 SHALL have frame_sel  input  1  to select the frame buffer (see Configuration).
REQ-008 SHALL have p1_cmd_full  input  1, p1_cmd_en  output  1, p1_cmd_instr  output  3, p1_cmd_bl  output  6 and p1_cmd_byte_addr  output  30 as the MIG command port.
REQ-009 SHALL have p1_rd_empty  input  1, p1_rd_count  input  7, p1_rd_data  input  32, p1_rd_overflow  input  1 and p1_rd_en  output  1 as the MIG read port (first-word-fall-through).
REQ-010 SHALL have pix_data  output  32, pix_valid  output  1 and pix_ready  input  1 as the downstream stream.
REQ-011 SHALL have frame_done  output  1 (one-cycle pulse) and overflow_err  output  1 (sticky).

Function
REQ-012 SHALL synchronise mem_calib_done through 2 flops, giving calib_ok.
REQ-013 SHALL implement the states WAIT_CALIB, IDLE, CMD, WAIT_DATA, STREAM and DONE.
REQ-014 WAIT_CALIB SHALL go to IDLE when calib_ok=1.
REQ-015 IDLE SHALL load ptr=frame base on frame_start and go to CMD.
REQ-016 CMD SHALL, when p1_cmd_full=0, pulse p1_cmd_en for 1 cycle with instr=3'b001, bl=63 and byte_addr=ptr, then advance ptr by 256 and go to WAIT_DATA.
REQ-017 CMD SHALL hold p1_cmd_en low while p1_cmd_full=1.
REQ-018 WAIT_DATA SHALL go to STREAM when p1_rd_empty=0.
REQ-019 In STREAM, p1_rd_en SHALL equal !p1_rd_empty && (!pix_valid || pix_ready), decoded combinationally from registered state.
REQ-020 On each p1_rd_en=1 cycle, pix_data SHALL register p1_rd_data, pix_valid SHALL set and the 7-bit burst word counter SHALL increment.
REQ-021 pix_valid SHALL clear when pix_ready=1 and no new word is loaded in the same cycle.
REQ-022 After the 64th word of a burst, the block SHALL go to CMD if ptr < base + FRAME_WORDS*4, else to DONE.
REQ-023 DONE SHALL pulse frame_done for 1 cycle, wait until pix_valid=0, then go to IDLE.
REQ-024 frame_start outside IDLE SHALL be latched as pending and serviced on the next entry to IDLE, with at most 1 pending request.
REQ-025 pix_data SHALL hold steady while pix_valid=1 && pix_ready=0.
REQ-026 If calib_ok falls in any state, the block SHALL go to WAIT_CALIB and clear p1_cmd_en, p1_rd_en, pix_valid and the pending request.
REQ-027 p1_rd_overflow=1 SHALL set overflow_err until reset.
REQ-028 ptr arithmetic SHALL be 30-bit unsigned with no wrap inside a frame.

Reset
REQ-029 With rst_n=0, the state SHALL be WAIT_CALIB.
REQ-030 With rst_n=0, ptr=BASE_ADDR, the counters, the pending request and all outputs SHALL be 0, including p1_cmd_instr, p1_cmd_bl and p1_cmd_byte_addr.
REQ-031 Reset SHALL take effect asynchronously and release synchronously through the 2-flop calib path.

Configuration
REQ-032 With DDR_READER_FRAME_SWAP_EN defined, the frame base SHALL be sampled at frame_start as BASE_ADDR + (frame_sel ? FRAME_WORDS*4 : 0).
REQ-033 Without DDR_READER_FRAME_SWAP_EN, the frame base SHALL be BASE_ADDR and frame_sel SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the state enum, MIG_CMD_WRITE=3'b000, MIG_CMD_READ=3'b001, BURST_WORDS=64 and BURST_BYTES=256, which are common with the port-0 writer.
REQ-035 One sub-module, ddr_rd_skid (the pix output register and handshake), SHALL be instantiated; everything else SHALL stay flat.

Verification
REQ-036 Reset then calib=1 then frame_start, with FRAME_WORDS=128: commands SHALL be issued at addresses 0 and 256, 128 words SHALL be output in order and frame_done SHALL pulse once.
REQ-037 pix_ready toggled 1/0 every cycle, with model FIFO data 0..63: the output SHALL have no drop or duplicate, and pix_data SHALL stay stable while stalled.
REQ-038 p1_cmd_full=1 for 10 cycles in CMD: p1_cmd_en SHALL stay 0 and then pulse exactly once.
REQ-039 With the macro on, frame_sel=1 and FRAME_WORDS=128: the first byte_addr SHALL be 512.
REQ-040 calib dropped mid-STREAM: the block SHALL be in WAIT_CALIB within 3 cycles with pix_valid=0.
REQ-041 p1_rd_overflow pulsed once: overflow_err=1 SHALL persist until rst_n=0.
